// File: rtl/register_dump.sv
`default_nettype none
// ============================================================================
// register_dump: mirrors process register writes and streams a snapshot of
// them, with a step count, over a valid/ready beat interface.
// Optional macro REGISTER_DUMP_AUTO_EN: a stop 0->1 edge also starts a dump.
// Revision: 1.0
// ============================================================================
module register_dump #(
  parameter int REGISTERS  = 16,
  parameter int WIDTH      = 8,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  writeEnable,
  input  logic [INDEX_BITS-1:0] writeIndex,
  input  logic [WIDTH-1:0]      writeData,
  input  logic                  stop,
  input  logic                  dumpRequest,
  output logic                  dumpBusy,
  output logic                  dumpValid,
  input  logic                  dumpReady,
  output logic [INDEX_BITS-1:0] dumpIndex,
  output logic [WIDTH-1:0]      dumpData,
  output logic                  dumpLast,
  output logic [31:0]           dumpStep
);

  localparam logic [0:0]            IDLE       = 1'b0;
  localparam logic [0:0]            SEND       = 1'b1;
  localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(REGISTERS - 1);
  localparam logic [INDEX_BITS:0]   REG_COUNT  = (INDEX_BITS + 1)'(REGISTERS);
  localparam logic [31:0]           STEP_MAX   = 32'hFFFF_FFFF;

  logic [0:0]                       state;
  logic [0:0]                       state_next;
  logic [REGISTERS-1:0][WIDTH-1:0]  shadow_vec;
  logic [INDEX_BITS-1:0]            beat_index;
  logic [31:0]                      step_count;
  logic [31:0]                      step_snap;
  logic                             start_request;
  logic                             capture;
  logic                             beat_done;
  logic                             write_valid;

  assign write_valid = writeEnable && ({1'b0, writeIndex} < REG_COUNT);
  assign capture     = (state == IDLE) && start_request;
  assign beat_done   = (state == SEND) && dumpReady;

`ifdef REGISTER_DUMP_AUTO_EN
  logic stop_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop;
    end
  end

  assign start_request = dumpRequest | (stop & ~stop_q);
`else
  assign start_request = dumpRequest;
`endif

  // Each register owns its mirror and shadow; the shadow takes the same-edge
  // write so a request coinciding with a write sees the new value.
  for (genvar g = 0; g < REGISTERS; g++) begin : g_reg
    logic             hit;
    logic [WIDTH-1:0] mirror_q;
    logic [WIDTH-1:0] shadow_q;

    assign hit = write_valid && (writeIndex == INDEX_BITS'(g));

    always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
        mirror_q <= '0;
        shadow_q <= '0;
      end else begin
        if (hit) begin
          mirror_q <= writeData;
        end
        if (capture) begin
          shadow_q <= hit ? writeData : mirror_q;
        end
      end
    end

    assign shadow_vec[g] = shadow_q;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      step_count <= '0;
    end else if (!stop && (step_count != STEP_MAX)) begin
      step_count <= step_count + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      step_snap  <= '0;
      beat_index <= '0;
    end else begin
      if (capture) begin
        step_snap  <= step_count;
        beat_index <= '0;
      end else if (beat_done) begin
        beat_index <= (beat_index == LAST_INDEX) ? '0 : beat_index + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_request) state_next = SEND;
      SEND:    if (dumpReady && (beat_index == LAST_INDEX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dumpValid = 1'b0;
    dumpBusy  = 1'b0;
    dumpIndex = '0;
    dumpData  = '0;
    dumpLast  = 1'b0;
    if (state == SEND) begin
      dumpValid = 1'b1;
      dumpBusy  = 1'b1;
      dumpIndex = beat_index;
      dumpData  = shadow_vec[beat_index];
      dumpLast  = (beat_index == LAST_INDEX);
    end
  end

  assign dumpStep = step_snap;

endmodule
`default_nettype wire

// File: tb/tb_register_dump.sv
`default_nettype none
// ============================================================================
// tb_register_dump: directed stimulus against a queue-based snapshot model.
// Revision: 1.0
// ============================================================================
module tb_register_dump;
  localparam int REGS = 16;
  localparam int W    = 8;
  localparam int IB   = 4;

  logic          clock = 1'b0;
  logic          resetN = 1'b1;
  logic          writeEnable = 1'b0;
  logic [IB-1:0] writeIndex = '0;
  logic [W-1:0]  writeData = '0;
  logic          stop = 1'b0;
  logic          dumpRequest = 1'b0;
  logic          dumpReady = 1'b0;
  logic          dumpBusy, dumpValid, dumpLast;
  logic [IB-1:0] dumpIndex;
  logic [W-1:0]  dumpData;
  logic [31:0]   dumpStep;

  int nvec = 0;
  int nerr = 0;

  register_dump #(.REGISTERS(REGS), .WIDTH(W), .INDEX_BITS(IB)) dut (
    .clock(clock), .resetN(resetN), .writeEnable(writeEnable),
    .writeIndex(writeIndex), .writeData(writeData), .stop(stop),
    .dumpRequest(dumpRequest), .dumpBusy(dumpBusy), .dumpValid(dumpValid),
    .dumpReady(dumpReady), .dumpIndex(dumpIndex), .dumpData(dumpData),
    .dumpLast(dumpLast), .dumpStep(dumpStep)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a dump is a queue of pending beats filled at the start edge.
  logic [W-1:0] m_mirror [REGS];
  logic [31:0]  m_step, m_cap;
  logic         m_prev_stop, m_auto, m_start;
  int           q_idx[$];
  logic [W-1:0] q_dat[$];

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      foreach (m_mirror[i]) m_mirror[i] = '0;
      m_step = 0; m_cap = 0; m_prev_stop = 1'b0;
      q_idx.delete(); q_dat.delete();
    end else begin
`ifdef REGISTER_DUMP_AUTO_EN
      m_auto = stop && !m_prev_stop;
`else
      m_auto = 1'b0;
`endif
      m_start = (q_idx.size() == 0) && (dumpRequest || m_auto);
      if (q_idx.size() != 0 && dumpReady) begin
        void'(q_idx.pop_front());
        void'(q_dat.pop_front());
      end
      if (m_start) begin
        for (int i = 0; i < REGS; i++) begin
          q_idx.push_back(i);
          q_dat.push_back((writeEnable && int'(writeIndex) == i) ? writeData : m_mirror[i]);
        end
        m_cap = m_step;
      end
      if (writeEnable && int'(writeIndex) < REGS) m_mirror[writeIndex] = writeData;
      if (!stop && m_step != 32'hFFFF_FFFF) m_step = m_step + 1;
      m_prev_stop = stop;
    end
  end

  logic ev;
  always @(negedge clock) begin
    ev = (q_idx.size() != 0);
    chk("valid", 32'(dumpValid), 32'(ev));
    chk("busy",  32'(dumpBusy),  32'(ev));
    chk("index", 32'(dumpIndex), ev ? 32'(q_idx[0]) : 32'd0);
    chk("data",  32'(dumpData),  ev ? 32'(q_dat[0]) : 32'd0);
    chk("last",  32'(dumpLast),  (ev && q_idx[0] == REGS - 1) ? 32'd1 : 32'd0);
    chk("step",  dumpStep, m_cap);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    dumpReady = 1'b1;
    while (dumpBusy && n < 40) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(dumpBusy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    #2 resetN = 1'b0;
    #10;
    chk("rst_valid", 32'(dumpValid), 32'd0);
    chk("rst_busy",  32'(dumpBusy),  32'd0);
    chk("rst_step",  dumpStep,       32'd0);
    tick();
    resetN = 1'b1;
    stop = 1'b0;

    // Ten running edges, then halt and request: step snapshot is 10.
    repeat (10) tick();
    stop = 1'b1; dumpRequest = 1'b1; dumpReady = 1'b0;
    tick();
    dumpRequest = 1'b0;
    chk("step10", dumpStep, 32'd10);
    chk("first_valid", 32'(dumpValid), 32'd1);
    chk("first_index", 32'(dumpIndex), 32'd0);
    dumpRequest = 1'b1;
    tick();
    dumpRequest = 1'b0;
    chk("held_index", 32'(dumpIndex), 32'd0);
    drain();
    tick();
    chk("req_ignored", 32'(dumpBusy), 32'd0);

    // Full readout of r0..r3 = 0..3.
    for (int i = 0; i < 4; i++) begin
      writeEnable = 1'b1; writeIndex = IB'(i); writeData = W'(i);
      tick();
    end
    writeEnable = 1'b0;
    dumpRequest = 1'b1; dumpReady = 1'b1;
    tick();
    dumpRequest = 1'b0;
    for (int b = 0; b < REGS; b++) begin
      chk("seq_index", 32'(dumpIndex), 32'(b));
      chk("seq_data",  32'(dumpData),  (b < 4) ? 32'(b) : 32'd0);
      chk("seq_last",  32'(dumpLast),  (b == REGS - 1) ? 32'd1 : 32'd0);
      tick();
    end
    chk("seq_done", 32'(dumpBusy), 32'd0);

    // Bypass on the request edge, and a write during SEND stays out of the shadow.
    writeEnable = 1'b1; writeIndex = 4'd5; writeData = 8'h7F;
    dumpRequest = 1'b1; dumpReady = 1'b0;
    tick();
    dumpRequest = 1'b0; writeData = 8'h11; dumpReady = 1'b1;
    tick();
    writeEnable = 1'b0;
    repeat (4) tick();
    chk("byp_index", 32'(dumpIndex), 32'd5);
    chk("byp_data",  32'(dumpData),  32'h7F);
    drain();
    dumpRequest = 1'b1; dumpReady = 1'b0;
    tick();
    dumpRequest = 1'b0; dumpReady = 1'b1;
    repeat (5) tick();
    chk("new_index", 32'(dumpIndex), 32'd5);
    chk("new_data",  32'(dumpData),  32'h11);
    drain();

    // Back-pressure: ready 1,0,0,1.
    dumpRequest = 1'b1; dumpReady = 1'b1;
    tick();
    dumpRequest = 1'b0;
    tick();
    chk("bp_idx_a", 32'(dumpIndex), 32'd1);
    chk("bp_dat_a", 32'(dumpData),  32'd1);
    dumpReady = 1'b0;
    tick();
    chk("bp_idx_b", 32'(dumpIndex), 32'd1);
    tick();
    chk("bp_idx_c", 32'(dumpIndex), 32'd1);
    chk("bp_dat_c", 32'(dumpData),  32'd1);
    dumpReady = 1'b1;
    tick();
    chk("bp_idx_d", 32'(dumpIndex), 32'd2);
    chk("bp_dat_d", 32'(dumpData),  32'd2);
    drain();

    // Reset in the middle of a readout.
    dumpRequest = 1'b1; dumpReady = 1'b1;
    tick();
    dumpRequest = 1'b0;
    repeat (7) tick();
    chk("pre_rst_index", 32'(dumpIndex), 32'd7);
    #2 resetN = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dumpValid), 32'd0);
    chk("mid_rst_busy",  32'(dumpBusy),  32'd0);
    chk("mid_rst_index", 32'(dumpIndex), 32'd0);
    chk("mid_rst_data",  32'(dumpData),  32'd0);
    chk("mid_rst_step",  dumpStep,       32'd0);
    stop = 1'b0;
    tick();
    resetN = 1'b1;
    dumpRequest = 1'b1;
    tick();
    dumpRequest = 1'b0;
    chk("post_rst_valid", 32'(dumpValid), 32'd1);
    chk("post_rst_step",  dumpStep,       32'd0);
    for (int b = 0; b < REGS; b++) begin
      chk("post_rst_data", 32'(dumpData), 32'd0);
      tick();
    end
    chk("post_rst_done", 32'(dumpBusy), 32'd0);

    // stop 0->1 without a request.
    dumpReady = 1'b0;
    stop = 1'b1;
    tick();
`ifdef REGISTER_DUMP_AUTO_EN
    chk("auto_start", 32'(dumpValid), 32'd1);
    chk("auto_index", 32'(dumpIndex), 32'd0);
    drain();
`else
    chk("no_auto", 32'(dumpValid), 32'd0);
`endif
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
